// File: rtl/pc_simt.sv
`default_nettype none
// ============================================================================
// Module   : pc_simt
// Purpose  : Block PC unit with a per-thread NZP file, an active-thread mask
//            and a reconvergence stack for divergent BRnzp branches.
//            Define PC_SIMT_DIVERGE_COUNT_EN to add the diverge_count output.
// Revision : 1.0
// ============================================================================
module pc_simt #(
  parameter int THREADS               = 4,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   launch,
  input  logic [THREADS-1:0]                     thread_enable,
  input  logic [2:0]                             core_state,
  input  logic [2:0]                             decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0]          decoded_immediate,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]       decoded_reconv_pc,
  input  logic                                   decoded_nzp_write_enable,
  input  logic                                   decoded_pc_mux,
  input  logic [THREADS*DATA_MEM_DATA_BITS-1:0]  alu_out,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]       current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]       next_pc,
  output logic [THREADS-1:0]                     active_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_depth,
`ifdef PC_SIMT_DIVERGE_COUNT_EN
  output logic [15:0]                            diverge_count,
`endif
  output logic                                   stack_overflow
);

  localparam int c_PA    = PROGRAM_MEM_ADDR_BITS;
  localparam int c_DB    = DATA_MEM_DATA_BITS;
  localparam int c_DW    = $clog2(STACK_DEPTH + 1);
  localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0]      c_EXECUTE = 3'b101;
  localparam logic [2:0]      c_UPDATE  = 3'b110;
  localparam logic [c_PA-1:0] c_NO_RPC  = {c_PA{1'b1}};
  localparam logic [c_DW-1:0] c_ONE     = c_DW'(1);
  localparam logic [c_DW-1:0] c_TWO     = c_DW'(2);

  logic [c_PA-1:0]    next_pc_q, next_pc_d;
  logic [THREADS-1:0] mask_q, mask_d;
  logic [c_PA-1:0]    rpc_q, rpc_d;
  logic [c_DW-1:0]    depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         nzp_q [THREADS];

  logic [c_PA-1:0]    stk_pc_q   [STACK_DEPTH];
  logic [THREADS-1:0] stk_mask_q [STACK_DEPTH];
  logic [c_PA-1:0]    stk_rpc_q  [STACK_DEPTH];

  logic [c_PA-1:0]    w_imm, w_pc_inc, w_target;
  logic [THREADS-1:0] w_take, w_not_take;
  logic               w_need_two, w_no_room, w_push1, w_push2, w_div;
  logic [c_IDX_W-1:0] w_wr0_idx, w_wr1_idx, w_top_idx;

  generate
    if (c_DB >= c_PA) begin : g_imm_trunc
      assign w_imm = decoded_immediate[c_PA-1:0];
    end else begin : g_imm_ext
      assign w_imm = {{(c_PA-c_DB){1'b0}}, decoded_immediate};
    end
  endgenerate

  always_comb begin
    w_take = '0;
    for (int i = 0; i < THREADS; i++)
      w_take[i] = mask_q[i] & (|(nzp_q[i] & decoded_nzp));
  end

  assign w_not_take = mask_q & ~w_take;
  assign w_pc_inc   = current_pc + 1'b1;
  assign w_need_two = (decoded_reconv_pc != rpc_q);
  assign w_no_room  = (32'(depth_q) + (w_need_two ? 32'd2 : 32'd1)) > 32'(STACK_DEPTH);
  assign w_wr0_idx  = c_IDX_W'(depth_q);
  assign w_wr1_idx  = c_IDX_W'(depth_q + c_ONE);
  assign w_top_idx  = c_IDX_W'(depth_q - c_ONE);

  always_comb begin
    next_pc_d = next_pc_q;
    mask_d    = mask_q;
    rpc_d     = rpc_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    w_target  = w_pc_inc;
    w_push1   = 1'b0;
    w_push2   = 1'b0;
    w_div     = 1'b0;
    if (core_state == c_EXECUTE) begin
      if (decoded_pc_mux && (w_take != '0)) begin
        w_target = w_imm;
        if (w_not_take != '0) begin
          w_div = 1'b1;
          // Without room for the whole frame, every active thread simply branches.
          if (w_no_room) begin
            ovf_d = 1'b1;
          end else begin
            w_push1 = w_need_two;
            w_push2 = 1'b1;
            mask_d  = w_take;
            rpc_d   = decoded_reconv_pc;
            depth_d = depth_q + (w_need_two ? c_TWO : c_ONE);
          end
        end
      end
      if (!w_push2 && (w_target == rpc_q) && (depth_q != '0)) begin
        next_pc_d = stk_pc_q[w_top_idx];
        mask_d    = stk_mask_q[w_top_idx];
        rpc_d     = stk_rpc_q[w_top_idx];
        depth_d   = depth_q - c_ONE;
      end else begin
        next_pc_d = w_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc_q <= '0;
      mask_q    <= '0;
      rpc_q     <= c_NO_RPC;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < THREADS; i++) nzp_q[i] <= 3'b000;
      for (int s = 0; s < STACK_DEPTH; s++) begin
        stk_pc_q[s]   <= '0;
        stk_mask_q[s] <= '0;
        stk_rpc_q[s]  <= '0;
      end
    end else if (launch) begin
      next_pc_q <= '0;
      mask_q    <= thread_enable;
      rpc_q     <= c_NO_RPC;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      next_pc_q <= next_pc_d;
      mask_q    <= mask_d;
      rpc_q     <= rpc_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      if ((core_state == c_UPDATE) && decoded_nzp_write_enable) begin
        for (int i = 0; i < THREADS; i++)
          if (mask_q[i]) nzp_q[i] <= alu_out[i*c_DB +: 3];
      end
      // The reconvergence frame sits below the not-taken frame so it pops last.
      if (w_push1) begin
        stk_pc_q[w_wr0_idx]   <= decoded_reconv_pc;
        stk_mask_q[w_wr0_idx] <= mask_q;
        stk_rpc_q[w_wr0_idx]  <= rpc_q;
        stk_pc_q[w_wr1_idx]   <= w_pc_inc;
        stk_mask_q[w_wr1_idx] <= w_not_take;
        stk_rpc_q[w_wr1_idx]  <= decoded_reconv_pc;
      end else if (w_push2) begin
        stk_pc_q[w_wr0_idx]   <= w_pc_inc;
        stk_mask_q[w_wr0_idx] <= w_not_take;
        stk_rpc_q[w_wr0_idx]  <= decoded_reconv_pc;
      end
    end
  end

`ifdef PC_SIMT_DIVERGE_COUNT_EN
  logic [15:0] div_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt_q <= '0;
    else if (launch)
      div_cnt_q <= '0;
    else if (w_div && (div_cnt_q != 16'hFFFF))
      div_cnt_q <= div_cnt_q + 16'd1;
  end
  assign diverge_count = div_cnt_q;
`endif

  assign next_pc        = next_pc_q;
  assign active_mask    = mask_q;
  assign stack_depth    = depth_q;
  assign stack_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_simt.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_simt
// Purpose  : Scoreboard bench for pc_simt (two-entry stack so nesting overflows).
// Revision : 1.0
// ============================================================================
module tb_pc_simt;
  localparam int T  = 4;
  localparam int DB = 8;
  localparam int PA = 8;
  localparam int SD = 2;
  localparam int DW = $clog2(SD + 1);
  localparam logic [2:0] EX  = 3'b101;
  localparam logic [2:0] UPD = 3'b110;

  logic              clk, reset, launch;
  logic [T-1:0]      thread_enable;
  logic [2:0]        core_state, decoded_nzp;
  logic [DB-1:0]     decoded_immediate;
  logic [PA-1:0]     decoded_reconv_pc, current_pc, next_pc;
  logic              decoded_nzp_write_enable, decoded_pc_mux;
  logic [T*DB-1:0]   alu_out;
  logic [T-1:0]      active_mask;
  logic [DW-1:0]     stack_depth;
  logic              stack_overflow;
`ifdef PC_SIMT_DIVERGE_COUNT_EN
  logic [15:0]       diverge_count;
`endif

  pc_simt #(
    .THREADS(T), .DATA_MEM_DATA_BITS(DB),
    .PROGRAM_MEM_ADDR_BITS(PA), .STACK_DEPTH(SD)
  ) dut (
    .clk(clk), .reset(reset), .launch(launch), .thread_enable(thread_enable),
    .core_state(core_state), .decoded_nzp(decoded_nzp),
    .decoded_immediate(decoded_immediate), .decoded_reconv_pc(decoded_reconv_pc),
    .decoded_nzp_write_enable(decoded_nzp_write_enable),
    .decoded_pc_mux(decoded_pc_mux), .alu_out(alu_out), .current_pc(current_pc),
    .next_pc(next_pc), .active_mask(active_mask), .stack_depth(stack_depth),
`ifdef PC_SIMT_DIVERGE_COUNT_EN
    .diverge_count(diverge_count),
`endif
    .stack_overflow(stack_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [PA-1:0] pc;
    logic [T-1:0]  mask;
    logic [DW-1:0] depth;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total, bad, next_id;
  logic do_chk, obs_q;

  // A step flagged for checking marks the following negedge as an output to score.
  always @(posedge clk) obs_q <= do_chk;

  task automatic idle_inputs();
    launch = 1'b0; core_state = 3'b000; decoded_nzp = 3'b000;
    decoded_immediate = '0; decoded_reconv_pc = '0; current_pc = '0;
    decoded_nzp_write_enable = 1'b0; decoded_pc_mux = 1'b0; alu_out = '0;
    do_chk = 1'b0;
  endtask

  task automatic fire(input logic chk, input logic [PA-1:0] epc,
                      input logic [T-1:0] em, input logic [DW-1:0] ed, input logic eo);
    if (chk) begin
      sb.push_back('{next_id, epc, em, ed, eo});
      next_id++;
    end
    do_chk = chk;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_launch(input logic [T-1:0] te);
    launch = 1'b1; thread_enable = te;
    fire(1'b1, 8'h00, te, '0, 1'b0);
  endtask

  task automatic ex_nb(input logic [PA-1:0] pc, input logic [PA-1:0] epc,
                       input logic [T-1:0] em, input logic [DW-1:0] ed, input logic eo);
    core_state = EX; current_pc = pc;
    fire(1'b1, epc, em, ed, eo);
  endtask

  task automatic ex_br(input logic [PA-1:0] pc, input logic [2:0] nzp,
                       input logic [DB-1:0] imm, input logic [PA-1:0] rpc,
                       input logic [PA-1:0] epc, input logic [T-1:0] em,
                       input logic [DW-1:0] ed, input logic eo);
    core_state = EX; current_pc = pc; decoded_pc_mux = 1'b1;
    decoded_nzp = nzp; decoded_immediate = imm; decoded_reconv_pc = rpc;
    fire(1'b1, epc, em, ed, eo);
  endtask

  task automatic upd(input logic [T*DB-1:0] alu);
    core_state = UPD; decoded_nzp_write_enable = 1'b1; alu_out = alu;
    fire(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rst_check(input string name);
    logic ok;
    ok = (next_pc === '0) && (active_mask === '0) && (stack_depth === '0) &&
         (stack_overflow === 1'b0);
`ifdef PC_SIMT_DIVERGE_COUNT_EN
    ok = ok && (diverge_count === 16'h0000);
`endif
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got pc=%h mask=%b depth=%0d ovf=%b, expected all zero",
               name, next_pc, active_mask, stack_depth, stack_overflow);
    end
  endtask

  initial begin
    total = 0; bad = 0; next_id = 0; obs_q = 1'b0;
    idle_inputs();
    thread_enable = '0;

    fork
      forever begin
        @(negedge clk);
        if (obs_q) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: output strobe with no expectation queued");
          end else begin
            mon_e = sb.pop_front();
            if (next_pc !== mon_e.pc || active_mask !== mon_e.mask ||
                stack_depth !== mon_e.depth || stack_overflow !== mon_e.ovf) begin
              bad++;
              $display("FAIL chk%0d: got pc=%h mask=%b depth=%0d ovf=%b, expected pc=%h mask=%b depth=%0d ovf=%b",
                       mon_e.id, next_pc, active_mask, stack_depth, stack_overflow,
                       mon_e.pc, mon_e.mask, mon_e.depth, mon_e.ovf);
            end
          end
        end
      end
    join_none

    reset = 1'b1;
    #1;
    rst_check("reset_state");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Launch, sequential PC, wrap, hold outside EXECUTE/UPDATE, uniform branches.
    do_launch(4'b1111);
    ex_nb(8'h05, 8'h06, 4'b1111, 2'd0, 1'b0);
    core_state = 3'b000; decoded_pc_mux = 1'b1; decoded_nzp = 3'b111;
    decoded_immediate = 8'h55; current_pc = 8'h33;
    fire(1'b1, 8'h06, 4'b1111, 2'd0, 1'b0);
    upd(32'h02020202);
    ex_br(8'h06, 3'b010, 8'h20, 8'h30, 8'h20, 4'b1111, 2'd0, 1'b0);
    ex_br(8'h20, 3'b100, 8'h30, 8'h40, 8'h21, 4'b1111, 2'd0, 1'b0);
    ex_nb(8'hFF, 8'h00, 4'b1111, 2'd0, 1'b0);

    // Divergence, then two pops back to the full mask.
    upd(32'h01010404);
    ex_br(8'h04, 3'b100, 8'h10, 8'h18, 8'h10, 4'b0011, 2'd2, 1'b0);
    ex_nb(8'h17, 8'h05, 4'b1100, 2'd1, 1'b0);
    ex_nb(8'h17, 8'h18, 4'b1111, 2'd0, 1'b0);

    // Nested divergence on a full stack overflows; the flag stays set.
    ex_br(8'h04, 3'b100, 8'h10, 8'h18, 8'h10, 4'b0011, 2'd2, 1'b0);
    upd(32'h02020204);
    ex_br(8'h10, 3'b100, 8'h14, 8'h16, 8'h14, 4'b0011, 2'd2, 1'b1);
    ex_nb(8'h17, 8'h05, 4'b1100, 2'd1, 1'b1);
    ex_br(8'h05, 3'b001, 8'h40, 8'h50, 8'h40, 4'b1100, 2'd1, 1'b1);
    ex_nb(8'h17, 8'h18, 4'b1111, 2'd0, 1'b1);
    ex_nb(8'hFE, 8'hFF, 4'b1111, 2'd0, 1'b1);

    // Launch beats a simultaneous EXECUTE and clears the overflow flag.
    launch = 1'b1; thread_enable = 4'b0111; core_state = EX; current_pc = 8'h05;
    fire(1'b1, 8'h00, 4'b0111, 2'd0, 1'b0);
    upd(32'h04020202);
    ex_br(8'h00, 3'b010, 8'h30, 8'h33, 8'h30, 4'b0111, 2'd0, 1'b0);
    ex_br(8'h30, 3'b001, 8'h50, 8'h60, 8'h31, 4'b0111, 2'd0, 1'b0);

    // Asynchronous reset mid-divergence.
    do_launch(4'b1111);
    upd(32'h01010404);
    ex_br(8'h04, 3'b100, 8'h10, 8'h18, 8'h10, 4'b0011, 2'd2, 1'b0);
    #6;
    reset = 1'b1;
    #1;
    rst_check("reset_async");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // NZP registers were cleared by reset, so no thread takes the branch.
    do_launch(4'b1111);
    ex_br(8'h00, 3'b111, 8'h20, 8'h30, 8'h01, 4'b1111, 2'd0, 1'b0);

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never observed, expected 0", sb.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pc_simt.md
Name: pc_simt

Overview:
- Per-block program counter unit with branch-divergence support, replacing the single-path per-thread PC.
- Keeps one shared PC, a per-thread NZP register file, an active-thread mask and a reconvergence stack.
- When a BRnzp splits the active threads, the unit runs the taken path, then the not-taken path, then reconverges with the original mask.
- Sits in the core next to the scheduler and is driven by the same core_state encoding.

Parameters:
- THREADS, 4: threads per block, one NZP register and one mask bit each.
- DATA_MEM_DATA_BITS, 8: width of each ALU result and of the immediate.
- PROGRAM_MEM_ADDR_BITS, 8: PC width. The all-ones address is reserved as NO_RPC and means "no reconvergence point".
- STACK_DEPTH, 8: reconvergence stack entries. Each entry is {pc, mask, rpc}.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- launch  in  1  one-cycle pulse that starts a block.
- thread_enable  in  THREADS  threads valid in this block; sampled on launch.
- core_state  in  3  core FSM state: EXECUTE=3'b101, UPDATE=3'b110.
- decoded_nzp  in  3  branch condition mask.
- decoded_immediate  in  DATA_MEM_DATA_BITS  branch target.
- decoded_reconv_pc  in  PROGRAM_MEM_ADDR_BITS  reconvergence PC of the current branch.
- decoded_nzp_write_enable  in  1  CMP result write.
- decoded_pc_mux  in  1  1 = BRnzp.
- alu_out  in  THREADS*DATA_MEM_DATA_BITS  flattened per-thread ALU results; thread i occupies slice i.
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC of the executing instruction.
- next_pc  out  PROGRAM_MEM_ADDR_BITS  registered next PC.
- active_mask  out  THREADS  threads that execute the current instruction.
- stack_depth  out  $clog2(STACK_DEPTH+1)  occupied stack entries.
- stack_overflow  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous): next_pc=0, active_mask=0, stack_depth=0, stack_overflow=0, every nzp=0, cur_rpc=NO_RPC. Outputs change immediately, with no clock edge needed.
- Launch:
  - Takes priority over everything else in the same cycle.
  - Sets next_pc=0, active_mask=thread_enable, stack empty, cur_rpc=NO_RPC, stack_overflow=0.
  - Leaves the NZP registers unchanged.
- UPDATE with decoded_nzp_write_enable: for every thread i with active_mask[i]=1, nzp[i] <= alu_out slice i bits [2:0]. Inactive threads keep their NZP.
- EXECUTE: updates registered outputs one cycle later. Evaluation order:
  1. Non-branch (decoded_pc_mux=0): target = current_pc+1, wrapping modulo 2^PROGRAM_MEM_ADDR_BITS.
  2. Branch: per thread, take[i] = active_mask[i] & |(nzp[i] & decoded_nzp). Let T = take and N = active_mask & ~take.
     - T=0: target = current_pc+1.
     - N=0: target = decoded_immediate, zero-extended or truncated to PC width.
     - Both non-zero (divergent), with R = decoded_reconv_pc:
       - If R != cur_rpc, push E1={pc=R, mask=active_mask, rpc=cur_rpc}.
       - Always push E2={pc=current_pc+1, mask=N, rpc=R}, on top of E1 when E1 is pushed.
       - Then active_mask=T, cur_rpc=R, target = decoded_immediate.
  3. Reconvergence: if target == cur_rpc and the stack is non-empty, pop the top entry: next_pc=entry.pc, active_mask=entry.mask, cur_rpc=entry.rpc. Otherwise next_pc=target.
     - At most one pop per EXECUTE.
     - A push and a pop never occur in the same cycle; the divergent target is the immediate, which never equals R by compiler contract.
- Overflow:
  - Trigger: a divergent branch needs more free entries than remain.
  - Response: no push, stack_overflow <= 1 (sticky until launch or reset), target = decoded_immediate, active_mask unchanged. All active threads branch.
- Outside EXECUTE, UPDATE and launch, all state holds.
- active_mask is always a subset of the last-launched thread_enable.

Optional Feature:
- Macro: PC_SIMT_DIVERGE_COUNT_EN.
- When defined:
  - Adds output diverge_count, 16 bits.
  - Increments by 1 on every divergent branch, including overflowing ones.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by launch.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. reset, then launch with thread_enable=4'b1111; EXECUTE non-branch at current_pc=8'h05 -> next_pc=8'h06, active_mask=4'b1111, stack_depth=0.
2. CMP writes nzp=3'b010 on all threads in UPDATE; BRz (decoded_nzp=3'b010, imm 8'h20) in EXECUTE -> next_pc=8'h20, active_mask=4'b1111, stack_depth=0. Repeat with decoded_nzp=3'b100 -> next_pc=current_pc+1.
3. Divergence: threads 0,1 nzp=3'b100, threads 2,3 nzp=3'b001. BRn at pc 8'h04, imm 8'h10, reconv 8'h18:
   - Branch -> next_pc=8'h10, active_mask=4'b0011, stack_depth=2.
   - EXECUTE at pc 8'h17 -> next_pc=8'h05, active_mask=4'b1100, stack_depth=1.
   - EXECUTE at pc 8'h17 again -> next_pc=8'h18, active_mask=4'b1111, stack_depth=0.
4. STACK_DEPTH=2, nested divergence inside case 3's taken path -> stack_overflow=1, next_pc=imm, active_mask unchanged; flag stays 1 until the next launch.
5. launch with thread_enable=4'b0111, thread 3 nzp differs from the others -> branch is uniform; no push, stack_depth=0.
6. Assert reset mid-divergence (stack_depth=2) between clock edges -> next_pc, active_mask and stack_depth read 0 before the next edge. With PC_SIMT_DIVERGE_COUNT_EN, diverge_count also reads 0.
